// File: rtl/zorro2_bus_master_if.sv
// Request/response handshake plus Zorro II pad-side signals of the bus-master engine.
// master = the engine's view; slave = the requester and bus-side view (card, bench).
interface zorro2_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        req_write;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [23:0] zA;
    logic        zREAD;
    logic        znAS;
    logic        znUDS;
    logic        znLDS;
    logic        zDOE;
    logic [15:0] zD_out;
    logic        zD_oe;
    logic [15:0] zD_in;
    logic        znDTACK;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_be, zD_in, znDTACK,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               zA, zREAD, znAS, znUDS, znLDS, zDOE, zD_out, zD_oe
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_be, zD_in, znDTACK,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               zA, zREAD, znAS, znUDS, znLDS, zDOE, zD_out, zD_oe
    );
endinterface

// File: rtl/zorro2_bus_master.sv
// Zorro II cycle initiator: one request -> registered /AS,/UDS,/LDS,DOE sequence gated by synchronized /DTACK.
// One request in flight, req_ready low while busy; ZM_TIMEOUT_EN aborts a DS phase with no /DTACK (rsp_err).
module zorro2_bus_master #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned AS_DS_CYC   = 14,
    parameter int unsigned DS_MIN_CYC  = 20,
    parameter int unsigned DOE_CYC     = 8,
    parameter int unsigned RECOVER_CYC = 13,
    parameter int unsigned TIMEOUT_CYC = 200
) (
    input logic                 z_sample_clk,
    input logic                 reset_n,
    zorro2_bus_master_if.master bus
);

    if (SETUP_CYC < 1 || SETUP_CYC > 255 || AS_DS_CYC < 1 || AS_DS_CYC > 255 ||
        DS_MIN_CYC < 1 || DS_MIN_CYC > 255 || DOE_CYC < 1 || DOE_CYC > 255 ||
        RECOVER_CYC < 1 || RECOVER_CYC > 255 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
        $error("zorro2_bus_master: cycle parameters must lie in 1..255");
    end

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_AS, S_DS, S_DOE, S_RECOVER} state_t;

    localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] AS_DS_LD   = 8'(AS_DS_CYC - 1);
    localparam logic [7:0] DS_MIN_LD  = 8'(DS_MIN_CYC - 1);
    localparam logic [7:0] DOE_LD     = 8'(DOE_CYC - 1);
    localparam logic [7:0] RECOVER_LD = 8'(RECOVER_CYC - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        dtack_meta, dtack_s;
    logic        write_q, write_nxt;
    logic [1:0]  be_q, be_nxt;
    logic [23:0] za_q, za_nxt;
    logic        zread_q, zread_nxt;
    logic        nas_q, nas_nxt;
    logic        nuds_q, nuds_nxt;
    logic        nlds_q, nlds_nxt;
    logic        zdoe_q, zdoe_nxt;
    logic        zd_oe_q, zd_oe_nxt;
    logic [15:0] zd_out_q, zd_out_nxt;
    logic        ready_q, ready_nxt;
    logic        rsp_valid_q, rsp_valid_nxt;
    logic        rsp_err_q, rsp_err_nxt;
    logic [15:0] rsp_rdata_q, rsp_rdata_nxt;
    logic        ds_done;
    logic        ds_abort;

`ifdef ZM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT_CYC - 1);
    logic [7:0] tcnt_q, tcnt_nxt;
    logic       err_q, err_nxt;
    assign ds_abort = (tcnt_q == TIMEOUT_LD);
`else
    assign ds_abort = 1'b0;
`endif

    // /DTACK is asynchronous to us: two flops before the FSM looks at it
    always_ff @(posedge z_sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            dtack_meta <= 1'b1;
            dtack_s    <= 1'b1;
        end else begin
            dtack_meta <= bus.znDTACK;
            dtack_s    <= dtack_meta;
        end
    end

    assign ds_done = (cnt == 8'd0) && !dtack_s;

    always_ff @(posedge z_sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            write_q     <= 1'b0;
            be_q        <= 2'b00;
            za_q        <= 24'd0;
            zread_q     <= 1'b1;
            nas_q       <= 1'b1;
            nuds_q      <= 1'b1;
            nlds_q      <= 1'b1;
            zdoe_q      <= 1'b0;
            zd_oe_q     <= 1'b0;
            zd_out_q    <= 16'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 16'd0;
`ifdef ZM_TIMEOUT_EN
            tcnt_q      <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            write_q     <= write_nxt;
            be_q        <= be_nxt;
            za_q        <= za_nxt;
            zread_q     <= zread_nxt;
            nas_q       <= nas_nxt;
            nuds_q      <= nuds_nxt;
            nlds_q      <= nlds_nxt;
            zdoe_q      <= zdoe_nxt;
            zd_oe_q     <= zd_oe_nxt;
            zd_out_q    <= zd_out_nxt;
            ready_q     <= ready_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_err_q   <= rsp_err_nxt;
            rsp_rdata_q <= rsp_rdata_nxt;
`ifdef ZM_TIMEOUT_EN
            tcnt_q      <= tcnt_nxt;
            err_q       <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
        write_nxt     = write_q;
        be_nxt        = be_q;
        za_nxt        = za_q;
        zread_nxt     = zread_q;
        nas_nxt       = nas_q;
        nuds_nxt      = nuds_q;
        nlds_nxt      = nlds_q;
        zdoe_nxt      = zdoe_q;
        zd_oe_nxt     = zd_oe_q;
        zd_out_nxt    = zd_out_q;
        ready_nxt     = ready_q;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = rsp_rdata_q;
`ifdef ZM_TIMEOUT_EN
        tcnt_nxt      = tcnt_q + 8'd1;
        err_nxt       = err_q;
`endif
        case (state)
            S_IDLE: begin
                ready_nxt = 1'b1;
                if (bus.req_valid && ready_q) begin
                    write_nxt  = bus.req_write;
                    be_nxt     = bus.req_be;
                    za_nxt     = bus.req_addr & 24'hFF_FFFE;
                    zread_nxt  = !bus.req_write;
                    zd_out_nxt = bus.req_wdata;
                    ready_nxt  = 1'b0;
                    state_nxt  = S_SETUP;
                    cnt_nxt    = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt == 8'd0) begin
                    nas_nxt   = 1'b0;
                    zd_oe_nxt = write_q;
                    state_nxt = S_AS;
                    cnt_nxt   = AS_DS_LD;
                end
            end
            S_AS: begin
                if (cnt == 8'd0) begin
                    nuds_nxt  = !be_q[1];
                    nlds_nxt  = !be_q[0];
                    state_nxt = S_DS;
                    cnt_nxt   = DS_MIN_LD;
`ifdef ZM_TIMEOUT_EN
                    tcnt_nxt  = 8'd0;
`endif
                end
            end
            S_DS: begin
                // a normal acknowledge wins over a timeout landing on the same clock
                if (ds_done || ds_abort) begin
                    if (ds_done && !write_q) begin
                        rsp_rdata_nxt = bus.zD_in;
                    end
`ifdef ZM_TIMEOUT_EN
                    err_nxt   = !ds_done;
`endif
                    nuds_nxt  = 1'b1;
                    nlds_nxt  = 1'b1;
                    zdoe_nxt  = 1'b1;
                    state_nxt = S_DOE;
                    cnt_nxt   = DOE_LD;
                end
            end
            S_DOE: begin
                if (cnt == 8'd0) begin
                    zdoe_nxt      = 1'b0;
                    nas_nxt       = 1'b1;
                    zd_oe_nxt     = 1'b0;
                    rsp_valid_nxt = 1'b1;
`ifdef ZM_TIMEOUT_EN
                    rsp_err_nxt   = err_q;
                    err_nxt       = 1'b0;
`endif
                    state_nxt     = S_RECOVER;
                    cnt_nxt       = RECOVER_LD;
                end
            end
            S_RECOVER: begin
                if (cnt == 8'd0) begin
                    ready_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.zA        = za_q;
    assign bus.zREAD     = zread_q;
    assign bus.znAS      = nas_q;
    assign bus.znUDS     = nuds_q;
    assign bus.znLDS     = nlds_q;
    assign bus.zDOE      = zdoe_q;
    assign bus.zD_out    = zd_out_q;
    assign bus.zD_oe     = zd_oe_q;

endmodule
